apple1_board_io: RTL
====================

// Module: apple1_board_io
// PURPOSE
//  Generic board-level I/O conditioner placed between the FPGA pins and the apple1 core.
//  - Generates a power-on/button reset for the core (sys_rst_n).
//  - Debounces NUM_BTN push buttons, with level and one-cycle press outputs.
//  - Registers the core's 1-bit VGA colours and fans each one out to COLOR_BITS pins.
//  - Supports an optional monochrome-green mode.
// PARAMETERS
//  NUM_BTN          2       number of push buttons; btn 0 is the reset button, >=1
//  BTN_ACTIVE_LOW   1       1: pin low = pressed; 0: pin high = pressed
//  DEBOUNCE_CYCLES  250000  consecutive stable samples required to accept a change, >=1 (10 ms @25 MHz)
//  POR_CYCLES       1024    sys_rst_n low time after reset/button release, >=1
//  RST_BTN_EN       1       1: btn 0 also resets the core; 0: btn 0 is an ordinary button
//  COLOR_BITS       2       output pins per colour channel, >=1
//  MONO_GREEN       0       1: grn = red|grn|blu, red = blu = 0 (green-phosphor look)
// PORTS
//  clk25          in   1          25 MHz pixel/system clock
//  rst            in   1          asynchronous, active-high reset
//  btn_in         in   NUM_BTN    raw button pins (asynchronous)
//  vga_red_in     in   1          core red
//  vga_grn_in     in   1          core green
//  vga_blu_in     in   1          core blue
//  vga_h_sync_in  in   1          core horizontal sync
//  vga_v_sync_in  in   1          core vertical sync
//  sys_rst_n      out  1          active-low reset to the apple1 core
//  btn_level      out  NUM_BTN    debounced state, 1 = pressed
//  btn_press      out  NUM_BTN    one-cycle pulse on debounced press
//  vga_red        out  COLOR_BITS registered red, every bit equal
//  vga_grn        out  COLOR_BITS registered green, every bit equal
//  vga_blu        out  COLOR_BITS registered blue, every bit equal
//  vga_h_sync     out  1          horizontal sync, delayed 1 cycle to match colours
//  vga_v_sync     out  1          vertical sync, delayed 1 cycle to match colours
// BEHAVIOUR
//  Reset values (async on rst):
//   - sys_rst_n=0, btn_level=0, btn_press=0.
//   - All colour outputs 0, vga_h_sync=vga_v_sync=1.
//   - Synchronisers are loaded with the "released" level.
//   - Debounce counters and the POR counter are 0.
//  Button path, per button and independent of the others:
//   - 2-FF synchroniser, then polarity normalised to 1 = pressed.
//   - Counter width is $clog2(DEBOUNCE_CYCLES+1); the counter saturates and never wraps.
//   - Sample equal to btn_level: counter cleared.
//   - Sample differs from btn_level: counter increments.
//   - On the edge where the counter reaches DEBOUNCE_CYCLES, btn_level toggles and the counter clears.
//   - Latency is pin change -> btn_level change = 2 + DEBOUNCE_CYCLES edges.
//   - Any glitch shorter than DEBOUNCE_CYCLES is ignored because the counter restarts.
//   - btn_press is high for exactly the one cycle in which btn_level goes 0->1; release gives no pulse.
//  Reset generator, 2-state FSM:
//   HOLD:
//    - sys_rst_n=0 and the POR counter increments.
//    - Counter reaches POR_CYCLES -> RUN, with sys_rst_n=1 from that edge.
//    - If RST_BTN_EN and btn_level[0]=1, the counter is cleared and stays 0 while pressed.
//   RUN:
//    - sys_rst_n=1.
//    - If RST_BTN_EN and btn_level[0] rises -> HOLD, with the counter cleared and sys_rst_n=0 on the next edge.
//   - Exit from rst always enters HOLD: a full POR_CYCLES stretch after rst falls.
//   - rst asserted in either state forces HOLD immediately (async).
//  Video path:
//   - Single register stage; colours and syncs share it, so alignment is exact (latency 1).
//   - MONO_GREEN=0: each channel is replicated COLOR_BITS times.
//   - MONO_GREEN=1: vga_grn = {COLOR_BITS{r|g|b}}, vga_red = vga_blu = 0.
//   - Syncs are never modified, and there is no blanking logic.
//   - During rst the video outputs hold their reset values.
// TESTING (bench params: NUM_BTN=2, DEBOUNCE_CYCLES=4, POR_CYCLES=8, BTN_ACTIVE_LOW=1, COLOR_BITS=2)
//  1 Release rst, btn_in=2'b11 -> sys_rst_n=0 for 8 edges, 1 from the 8th edge; btn_level=0 and btn_press=0 throughout.
//  2 btn_in[1] 1->0 held -> btn_level[1]=1 at edge 6; btn_press[1]=1 for that cycle only; release -> level 0 after 6 edges, no pulse.
//  3 btn_in[1] low 3 cycles, high 1, low 3 (bounce) -> btn_level[1] stays 0; held low afterwards -> rises 6 edges after last fall.
//  4 In RUN, btn_in[0] low 20 cycles, then high -> sys_rst_n falls 1 edge after btn_level[0] rises, stays 0 while held, returns 1 8 edges after btn_level[0] falls.
//  5 red/grn/blu_in=1/0/1, hsync=0 at edge N -> at edge N+1 vga_red=2'b11, vga_grn=2'b00, vga_blu=2'b11, vga_h_sync=0; MONO_GREEN=1 -> vga_grn=2'b11, red=blu=2'b00.
//  6 Assert rst mid-HOLD and mid-debounce -> all outputs take reset values immediately; after release a full 8-cycle POR runs and btn_level=0.

Source files
------------

// File: rtl/apple1_board_io.sv
// apple1_board_io
//   Board-level I/O conditioner between the FPGA pins and the apple1 core.
//   Generates the core reset (power-on stretch plus optional reset button),
//   debounces the push buttons, and registers and fans out the 1-bit VGA
//   colour signals, with an optional monochrome-green look.
//
//   Ports
//     clk25          in   pixel/system clock (25 MHz)
//     rst            in   asynchronous active-high reset
//     btn_in         in   raw button pins, asynchronous to clk25
//     vga_*_in       in   core colour and sync signals
//     sys_rst_n      out  active-low reset to the core
//     btn_level      out  debounced button state, 1 = pressed
//     btn_press      out  one-cycle pulse when btn_level goes 0->1
//     vga_red/grn/blu out registered colours, each bit a copy of the channel
//     vga_h_sync/v_sync out syncs, one register stage to match the colours
//
//   Reset generator states
//     state  | meaning
//     S_HOLD | sys_rst_n low, POR counter running (held at 0 while btn 0 pressed)
//     S_RUN  | sys_rst_n high, core running
module apple1_board_io #(
    parameter int NUM_BTN         = 2,
    parameter int BTN_ACTIVE_LOW  = 1,
    parameter int DEBOUNCE_CYCLES = 250000,
    parameter int POR_CYCLES      = 1024,
    parameter int RST_BTN_EN      = 1,
    parameter int COLOR_BITS      = 2,
    parameter int MONO_GREEN      = 0
) (
    input  logic                  clk25,
    input  logic                  rst,
    input  logic [NUM_BTN-1:0]    btn_in,
    input  logic                  vga_red_in,
    input  logic                  vga_grn_in,
    input  logic                  vga_blu_in,
    input  logic                  vga_h_sync_in,
    input  logic                  vga_v_sync_in,
    output logic                  sys_rst_n,
    output logic [NUM_BTN-1:0]    btn_level,
    output logic [NUM_BTN-1:0]    btn_press,
    output logic [COLOR_BITS-1:0] vga_red,
    output logic [COLOR_BITS-1:0] vga_grn,
    output logic [COLOR_BITS-1:0] vga_blu,
    output logic                  vga_h_sync,
    output logic                  vga_v_sync
);

    localparam int DB_W  = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int POR_W = $clog2(POR_CYCLES + 1);

    localparam logic [DB_W-1:0]  DB_LAST  = DB_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [POR_W-1:0] POR_LAST = POR_W'(POR_CYCLES - 1);

    // Pin level that means "released"; also the XOR mask that turns a pin
    // sample into 1 = pressed.
    localparam logic BTN_REL  = (BTN_ACTIVE_LOW != 0);
    localparam logic BTN_RST  = (RST_BTN_EN != 0);
    localparam logic MONO     = (MONO_GREEN != 0);

    // ------------------------------------------------------------------
    // Button synchronise + debounce
    // ------------------------------------------------------------------
    for (genvar i = 0; i < NUM_BTN; i++) begin : g_btn
        logic            sync1;
        logic            sync2;
        logic            pressed;
        logic [DB_W-1:0] cnt;
        logic            level_r;
        logic            press_r;

        assign pressed      = sync2 ^ BTN_REL;
        assign btn_level[i] = level_r;
        assign btn_press[i] = press_r;

        always_ff @(posedge clk25 or posedge rst) begin
            if (rst) begin
                sync1   <= BTN_REL;
                sync2   <= BTN_REL;
                cnt     <= '0;
                level_r <= 1'b0;
                press_r <= 1'b0;
            end else begin
                sync1   <= btn_in[i];
                sync2   <= sync1;
                press_r <= 1'b0;
                if (pressed == level_r) begin
                    cnt <= '0;
                end else if (cnt >= DB_LAST) begin
                    // This edge is the one where the count reaches
                    // DEBOUNCE_CYCLES: accept the new level.
                    level_r <= pressed;
                    press_r <= pressed;
                    cnt     <= '0;
                end else begin
                    cnt <= cnt + 1'b1;
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Reset generator
    // ------------------------------------------------------------------
    typedef enum logic {
        S_HOLD = 1'b0,
        S_RUN  = 1'b1
    } state_t;

    state_t           state;
    logic [POR_W-1:0] por_cnt;

    always_ff @(posedge clk25 or posedge rst) begin
        if (rst) begin
            state     <= S_HOLD;
            por_cnt   <= '0;
            sys_rst_n <= 1'b0;
        end else begin
            case (state)
                S_HOLD: begin
                    sys_rst_n <= 1'b0;
                    if (BTN_RST && btn_level[0]) begin
                        por_cnt <= '0;
                    end else if (por_cnt >= POR_LAST) begin
                        state     <= S_RUN;
                        sys_rst_n <= 1'b1;
                        por_cnt   <= '0;
                    end else begin
                        por_cnt <= por_cnt + 1'b1;
                    end
                end
                S_RUN: begin
                    sys_rst_n <= 1'b1;
                    // btn_press[0] marks the cycle right after btn_level[0] rose.
                    if (BTN_RST && btn_press[0]) begin
                        state     <= S_HOLD;
                        sys_rst_n <= 1'b0;
                        por_cnt   <= '0;
                    end
                end
                default: begin
                    state     <= S_HOLD;
                    sys_rst_n <= 1'b0;
                    por_cnt   <= '0;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Video: one register stage shared by colours and syncs
    // ------------------------------------------------------------------
    always_ff @(posedge clk25 or posedge rst) begin
        if (rst) begin
            vga_red    <= '0;
            vga_grn    <= '0;
            vga_blu    <= '0;
            vga_h_sync <= 1'b1;
            vga_v_sync <= 1'b1;
        end else begin
            if (MONO) begin
                vga_red <= '0;
                vga_grn <= {COLOR_BITS{vga_red_in | vga_grn_in | vga_blu_in}};
                vga_blu <= '0;
            end else begin
                vga_red <= {COLOR_BITS{vga_red_in}};
                vga_grn <= {COLOR_BITS{vga_grn_in}};
                vga_blu <= {COLOR_BITS{vga_blu_in}};
            end
            vga_h_sync <= vga_h_sync_in;
            vga_v_sync <= vga_v_sync_in;
        end
    end

endmodule
